// File: rtl/apb4_slave.sv
// APB4 completer: bank of N_REGS data registers with byte strobes, separate read/write wait states
// and decode errors. Define APB4_SLAVE_PROT_EN to make PRIV_MASK registers reject unprivileged access.
module apb4_slave #(
  parameter int                N_BIT_DATA    = 32,
  parameter int                N_BIT_ADDRESS = 6,
  parameter int                N_REGS        = 12,
  parameter int                READ_WAIT     = 2,
  parameter int                WRITE_WAIT    = 1,
  parameter logic [N_REGS-1:0] PRIV_MASK     = 'h1
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [N_BIT_ADDRESS-1:0]     PADDR,
  input  logic [N_BIT_DATA-1:0]        PWDATA,
  input  logic [N_BIT_DATA/8-1:0]      PSTRB,
  input  logic [2:0]                   PPROT,
  output logic [N_BIT_DATA-1:0]        PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [N_REGS*N_BIT_DATA-1:0] REGS_OUT
);

  localparam int LANES = N_BIT_DATA / 8;
  localparam int IDX_W = N_BIT_ADDRESS - 2;
  localparam int LIMIT = 4 * N_REGS;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                    r_state, w_next;
  logic [3:0]                r_cnt;
  logic [N_BIT_ADDRESS-1:0]  r_addr;
  logic                      r_write;
  logic [N_BIT_DATA-1:0]     r_wdata;
  logic [LANES-1:0]          r_strb;
  logic [N_BIT_DATA-1:0]     r_regs [N_REGS];

  logic                      w_setup, w_active, w_ready, w_done;
  logic                      w_dec_err, w_prot_err, w_err, w_commit;
  logic [IDX_W-1:0]          w_idx;
  logic [N_BIT_DATA-1:0]     w_rdata;

  assign w_setup   = PSEL & ~PENABLE;
  assign w_active  = PSEL & PENABLE;
  // PREADY depends only on registered state so no input reaches it combinationally
  assign w_ready   = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_done    = w_ready & w_active;
  assign w_idx     = r_addr[N_BIT_ADDRESS-1:2];
  assign w_dec_err = ({1'b0, r_addr} >= (N_BIT_ADDRESS+1)'(LIMIT)) || (r_addr[1:0] != 2'b00);

`ifdef APB4_SLAVE_PROT_EN
  logic       r_priv;
  logic [1:0] w_unused_prot;
  assign w_unused_prot = PPROT[2:1];

  always_ff @(posedge PCLK) begin
    if (r_state == S_IDLE && w_setup) r_priv <= PPROT[0];
  end

  always_comb begin
    w_prot_err = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin
      if (w_idx == IDX_W'(i) && PRIV_MASK[i] && !r_priv) w_prot_err = 1'b1;
    end
  end
`else
  logic [N_REGS+2:0] w_unused_prot;
  assign w_unused_prot = {PRIV_MASK, PPROT};
  assign w_prot_err    = 1'b0;
`endif

  assign w_err    = w_dec_err | w_prot_err;
  assign w_commit = w_done & r_write & ~w_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_setup) w_next = S_ACCESS;
      S_ACCESS: if (!w_active || w_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_IDLE && w_setup) begin
      r_cnt <= PWRITE ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
    end else if (r_state == S_ACCESS) begin
      if (!w_active)          r_cnt <= 4'd0;
      else if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Setup-phase capture; later bus changes within the transfer are ignored
  always_ff @(posedge PCLK) begin
    if (r_state == S_IDLE && w_setup) begin
      r_addr  <= PADDR;
      r_write <= PWRITE;
      r_wdata <= PWDATA;
      r_strb  <= PSTRB;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        for (int k = 0; k < LANES; k++) begin
          if (w_commit && w_idx == IDX_W'(i) && r_strb[k])
            r_regs[i][8*k +: 8] <= r_wdata[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (w_idx == IDX_W'(i)) w_rdata = r_regs[i];
    end
  end

  assign PREADY  = w_ready;
  assign PSLVERR = w_ready & w_err;
  assign PRDATA  = (w_ready && !r_write && !w_err) ? w_rdata : '0;

  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign REGS_OUT[g*N_BIT_DATA +: N_BIT_DATA] = r_regs[g];
  end

endmodule

// File: tb/tb_apb4_slave.sv
// Self-checking bench for apb4_slave: directed scenarios then randomized transfers
// against a word-array reference model.
module tb_apb4_slave;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 12;
  localparam int RW = 2;
  localparam int WW = 1;
`ifdef APB4_SLAVE_PROT_EN
  localparam logic [NR-1:0] PM = 'h1;
`endif

  logic             PCLK = 1'b0;
  logic             PRESET, PSEL, PENABLE, PWRITE;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA;
  logic [DW/8-1:0]  PSTRB;
  logic [2:0]       PPROT;
  logic [DW-1:0]    PRDATA;
  logic             PREADY, PSLVERR;
  logic [NR*DW-1:0] REGS_OUT;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] m_regs [NR];

  apb4_slave #(.N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .N_REGS(NR),
               .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .REGS_OUT(REGS_OUT)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  function automatic bit exp_err(input logic [AW-1:0] a, input logic [2:0] p);
    int idx;
    bit e;
    idx = int'(a) / 4;
    e = (int'(a) >= 4*NR) || (int'(a) % 4 != 0);
`ifdef APB4_SLAVE_PROT_EN
    if (!e && PM[idx] && !p[0]) e = 1'b1;
`else
    if (p == 3'd7 && idx < 0) e = 1'b1;
`endif
    return e;
  endfunction

  // Caller is just after a rising edge; returns just after the completion edge.
  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] s, input logic [2:0] p, input bit idle_after);
    int n;
    bit err;
    logic [DW-1:0] exp_rd;
    err    = exp_err(a, p);
    exp_rd = (w || err) ? '0 : m_regs[int'(a)/4];
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s; PPROT = p;
    @(negedge PCLK);
    chk("idle_pready", PREADY, 0);
    chk("idle_pslverr", PSLVERR, 0);
    chk("regs_out", REGS_OUT, model_flat());
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PWDATA = $urandom; PSTRB = 4'($urandom); PADDR = AW'($urandom);
    PWRITE = ~w; PPROT = 3'($urandom);
    n = 1;
    forever begin
      @(negedge PCLK);
      if (PREADY || n >= 20) break;
      @(posedge PCLK); #1;
      n++;
    end
    chk("latency", n, w ? WW+1 : RW+1);
    chk("pslverr", PSLVERR, err);
    chk("prdata", PRDATA, exp_rd);
    @(posedge PCLK); #1;
    if (w && !err)
      for (int k = 0; k < DW/8; k++)
        if (s[k]) m_regs[int'(a)/4][8*k +: 8] = d[8*k +: 8];
    if (idle_after) begin PSEL = 1'b0; PENABLE = 1'b0; end
  endtask

  initial begin
    logic [AW-1:0] ra;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_regs", REGS_OUT, 0);
    @(posedge PCLK); #1;

    xfer(1, 6'h04, 32'hDEADBEEF, 4'hF, 3'd1, 1);
    xfer(0, 6'h04, 32'h0, 4'h0, 3'd1, 1);
    chk("reg1_deadbeef", REGS_OUT[63:32], 32'hDEADBEEF);

    xfer(1, 6'h08, 32'hAABBCCDD, 4'hF, 3'd1, 1);
    xfer(1, 6'h08, 32'h11223344, 4'b0101, 3'd1, 1);
    xfer(0, 6'h08, 32'h0, 4'h0, 3'd1, 1);
    chk("reg2_strobe", REGS_OUT[95:64], 32'hAA22CC44);

    xfer(0, 6'h30, 32'h0, 4'hF, 3'd1, 1);
    xfer(0, 6'h05, 32'h0, 4'hF, 3'd1, 1);
    xfer(1, 6'h31, 32'h12345678, 4'hF, 3'd1, 1);
    xfer(1, 6'h06, 32'h12345678, 4'hF, 3'd1, 1);

    xfer(1, 6'h00, 32'h5, 4'hF, 3'd0, 1);
`ifdef APB4_SLAVE_PROT_EN
    chk("prot_reg0_blocked", REGS_OUT[31:0], 32'h0);
`else
    chk("noprot_reg0_written", REGS_OUT[31:0], 32'h5);
`endif
    xfer(1, 6'h00, 32'h5, 4'hF, 3'd1, 1);
    chk("priv_reg0_written", REGS_OUT[31:0], 32'h5);

    xfer(1, 6'h0C, 32'hCAFEF00D, 4'hF, 3'd1, 0);
    xfer(0, 6'h0C, 32'h0, 4'h0, 3'd1, 1);
    xfer(1, 6'h0C, 32'hFFFFFFFF, 4'h0, 3'd1, 1);
    chk("strb0_nochange", REGS_OUT[127:96], 32'hCAFEF00D);

    // Write aborted in its completion cycle must not commit
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'h10; PWDATA = 32'h0BADF00D;
    PSTRB = 4'hF; PPROT = 3'd1;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("abort_ready_before", PREADY, 1);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_pready", PREADY, 0);
    chk("abort_regs", REGS_OUT, model_flat());

    // Read aborted mid-wait, then a normal transfer must start cleanly
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 6'h08;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PENABLE = 1'b0; PSEL = 1'b0;
    repeat (2) begin
      @(negedge PCLK);
      chk("midwait_abort_pready", PREADY, 0);
    end
    @(posedge PCLK); #1;
    xfer(0, 6'h08, 32'h0, 4'h0, 3'd1, 1);

    // Reset in the completion cycle of a write discards it
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'h14; PWDATA = 32'h77777777;
    PSTRB = 4'hF; PPROT = 3'd1;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("rstmid_ready_before", PREADY, 1);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("rstmid_pready", PREADY, 0);
    chk("rstmid_regs", REGS_OUT, 0);
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    @(posedge PCLK); #1;

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) ra = AW'($urandom);
      else                           ra = AW'($urandom_range(0, NR-1) * 4);
      xfer(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom), 3'($urandom),
           1'($urandom_range(0, 1)));
    end
    xfer(0, 6'h00, 32'h0, 4'h0, 3'd1, 1);
    @(negedge PCLK);
    chk("final_regs", REGS_OUT, model_flat());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
